// File: rtl/dmac_pkg.sv
// Shared types and constants for the DMA copy engine: FSM state encoding,
// response codes and the burst sizing helper.
package dmac_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RREQ  = 3'd1,
    RDATA = 3'd2,
    WREQ  = 3'd3,
    WDATA = 3'd4,
    WRESP = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY      = 2'b00;
  localparam int         BYTES_PER_BEAT = 4;
  localparam int         BEAT_SHIFT     = $clog2(BYTES_PER_BEAT);
  localparam int         BEAT_CNT_W     = 5;

  // Beats in the next burst: whatever is left, capped at the burst limit.
  function automatic logic [BEAT_CNT_W-1:0] burst_beats(input logic [13:0] rem,
                                                        input int          max_burst);
    if (rem >= 14'(max_burst)) return BEAT_CNT_W'(max_burst);
    else                       return rem[BEAT_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/dmac_if.sv
// AXI-style read/write bus between the copy engine (master) and memory (slave).
// A beat transfers on a rising clk edge where valid and ready are both 1; a source
// that raises valid holds valid and its payload unchanged until that edge, ready may toggle freely.
interface dmac_if #(parameter int DATA_W = 32);

  logic              arvalid;
  logic              arready;
  logic [31:0]       araddr;
  logic [3:0]        arlen;

  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;

  logic              awvalid;
  logic              awready;
  logic [31:0]       awaddr;
  logic [3:0]        awlen;

  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic              wlast;

  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;

  modport master (
    output arvalid, araddr, arlen, rready, awvalid, awaddr, awlen,
           wvalid, wdata, wlast, bready,
    input  arready, rvalid, rdata, rresp, rlast, awready, wready, bvalid, bresp
  );

  modport slave (
    input  arvalid, araddr, arlen, rready, awvalid, awaddr, awlen,
           wvalid, wdata, wlast, bready,
    output arready, rvalid, rdata, rresp, rlast, awready, wready, bvalid, bresp
  );

endinterface

// File: rtl/dmac_fifo.sv
// Synchronous FIFO holding one read burst until it is written out.
// Pushes when full and pops when empty are dropped.
module dmac_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

endmodule

// File: rtl/dmac_engine.sv
// DMA copy engine: per start pulse, reads src in INCR bursts into a FIFO and writes them to dst.
// Optional DMAC_ENGINE_ERR_EN: non-OKAY read/write responses set err_o and stop after the current burst.
module dmac_engine
  import dmac_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int DATA_W    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] src_addr_i,
  input  logic [31:0] dst_addr_i,
  input  logic [15:0] byte_len_i,
  input  logic        start_i,
  output logic        done_o,
  output logic        err_o,
  output state_t      dbg_state_o,
  dmac_if.master      bus
);

  state_t                r_state;
  logic [31:0]           r_src;
  logic [31:0]           r_dst;
  logic [13:0]           r_rem;
  logic [BEAT_CNT_W-1:0] r_burst;
  logic [BEAT_CNT_W-1:0] r_rcnt;
  logic [BEAT_CNT_W-1:0] r_wcnt;
  logic                  r_arvalid;
  logic                  r_rready;
  logic                  r_awvalid;
  logic                  r_bready;
  logic                  r_done;
  logic                  r_err;
  logic [31:0]           r_araddr;
  logic [31:0]           r_awaddr;
  logic [3:0]            r_arlen;
  logic [3:0]            r_awlen;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [DATA_W-1:0]     w_fifo_data;
  logic                  w_wvalid;
  logic                  w_wlast;
  logic                  w_r_err;
  logic                  w_b_err;
  logic [13:0]           w_rem_next;
  logic [31:0]           w_step;
  logic [31:0]           w_src_next;
  logic [31:0]           w_dst_next;
  logic [BEAT_CNT_W-1:0] w_next_burst;
  logic [BEAT_CNT_W-1:0] w_start_burst;
  logic                  w_stop;
  logic                  w_unused_ok;

  dmac_fifo #(
    .DEPTH (MAX_BURST),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (bus.rdata),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign w_push   = r_rready && bus.rvalid;
  assign w_wvalid = (r_state == WDATA) && !w_fifo_empty;
  assign w_pop    = w_wvalid && bus.wready;
  // Last write beat is counted against beats actually received, since rlast ends the read.
  assign w_wlast  = (r_wcnt == (r_rcnt - 5'd1));

`ifdef DMAC_ENGINE_ERR_EN
  assign w_r_err     = w_push && (bus.rresp != RESP_OKAY);
  assign w_b_err     = bus.bresp != RESP_OKAY;
  assign err_o       = r_err;
  assign w_unused_ok = ^{src_addr_i[1:0], dst_addr_i[1:0], byte_len_i[1:0]};
`else
  assign w_r_err     = 1'b0;
  assign w_b_err     = 1'b0;
  assign err_o       = 1'b0;
  assign w_unused_ok = ^{src_addr_i[1:0], dst_addr_i[1:0], byte_len_i[1:0],
                         bus.rresp, bus.bresp};
`endif

  assign w_rem_next    = r_rem - 14'(r_burst);
  assign w_step        = 32'(r_burst) << BEAT_SHIFT;
  assign w_src_next    = r_src + w_step;
  assign w_dst_next    = r_dst + w_step;
  assign w_next_burst  = burst_beats(w_rem_next, MAX_BURST);
  assign w_start_burst = burst_beats(byte_len_i[15:2], MAX_BURST);
  assign w_stop        = (w_rem_next == 14'd0) || r_err || w_b_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_src     <= '0;
      r_dst     <= '0;
      r_rem     <= '0;
      r_burst   <= '0;
      r_rcnt    <= '0;
      r_wcnt    <= '0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_awvalid <= 1'b0;
      r_bready  <= 1'b0;
      r_done    <= 1'b1;
      r_err     <= 1'b0;
      r_araddr  <= '0;
      r_awaddr  <= '0;
      r_arlen   <= '0;
      r_awlen   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_src <= {src_addr_i[31:2], 2'b00};
            r_dst <= {dst_addr_i[31:2], 2'b00};
            r_rem <= byte_len_i[15:2];
            r_err <= 1'b0;
            if (byte_len_i[15:2] != 14'd0) begin
              r_burst   <= w_start_burst;
              r_araddr  <= {src_addr_i[31:2], 2'b00};
              r_arlen   <= 4'(w_start_burst - 5'd1);
              r_arvalid <= 1'b1;
              r_done    <= 1'b0;
              r_state   <= RREQ;
            end
          end
        end
        RREQ: begin
          if (bus.arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_rcnt    <= '0;
            r_state   <= RDATA;
          end
        end
        RDATA: begin
          if (w_push && !w_fifo_full) r_rcnt <= r_rcnt + 5'd1;
          if (w_r_err) r_err <= 1'b1;
          if (w_push && bus.rlast) begin
            r_rready  <= 1'b0;
            r_awvalid <= 1'b1;
            r_awaddr  <= r_dst;
            r_awlen   <= 4'(r_burst - 5'd1);
            r_wcnt    <= '0;
            r_state   <= WREQ;
          end
        end
        WREQ: begin
          if (bus.awready) begin
            r_awvalid <= 1'b0;
            r_state   <= WDATA;
          end
        end
        WDATA: begin
          if (w_pop) begin
            r_wcnt <= r_wcnt + 5'd1;
            if (w_wlast) begin
              r_bready <= 1'b1;
              r_state  <= WRESP;
            end
          end
        end
        WRESP: begin
          if (bus.bvalid) begin
            r_bready <= 1'b0;
            r_src    <= w_src_next;
            r_dst    <= w_dst_next;
            r_rem    <= w_rem_next;
            if (w_b_err) r_err <= 1'b1;
            if (w_stop) begin
              r_done  <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_burst   <= w_next_burst;
              r_araddr  <= w_src_next;
              r_arlen   <= 4'(w_next_burst - 5'd1);
              r_arvalid <= 1'b1;
              r_state   <= RREQ;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.arvalid = r_arvalid;
  assign bus.araddr  = r_araddr;
  assign bus.arlen   = r_arlen;
  assign bus.rready  = r_rready;
  assign bus.awvalid = r_awvalid;
  assign bus.awaddr  = r_awaddr;
  assign bus.awlen   = r_awlen;
  assign bus.wvalid  = w_wvalid;
  assign bus.wdata   = w_fifo_data;
  assign bus.wlast   = w_wvalid && w_wlast;
  assign bus.bready  = r_bready;

  assign done_o      = r_done;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_dmac_engine.sv
// Bench for dmac_engine: table of copy jobs against a memory slave with optional random stalls,
// plus hand-written reset-in-RDATA and start-during-WDATA sequences.
`timescale 1ns/1ps
module tb_dmac_engine;
  import dmac_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] src_addr_i = '0;
  logic [31:0] dst_addr_i = '0;
  logic [15:0] byte_len_i = '0;
  logic        start_i    = 1'b0;
  logic        done_o;
  logic        err_o;
  state_t      dbg_state_o;

  dmac_if #(.DATA_W(32)) bus();

  dmac_engine #(.MAX_BURST(16), .DATA_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src_addr_i  (src_addr_i),
    .dst_addr_i  (dst_addr_i),
    .byte_len_i  (byte_len_i),
    .start_i     (start_i),
    .done_o      (done_o),
    .err_o       (err_o),
    .dbg_state_o (dbg_state_o),
    .bus         (bus)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [0:4095];
  logic [35:0] exp_ar_q[$];
  logic [35:0] exp_aw_q[$];
  logic [31:0] exp_q[$];
  logic [35:0] rd_q[$];
  logic [35:0] wr_q[$];
  int          r_beat = 0;
  int          w_beat = 0;
  int          b_pend = 0;
  int          b_idx = 0;
  int          ar_count = 0;
  logic [3:0]  last_arlen = '0;
  bit          g_stall = 1'b0;
  int          g_err_b = -1;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    bit          stall;
    bit          poke;
    int          err_b;
    int          exp_nar;
    logic [3:0]  exp_last;
    bit          exp_err;
  } vec_t;

  vec_t vecs[10];

  function automatic int unsigned widx(input logic [31:0] a);
    return int'(a[13:2]);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got 0x%0h expected no such event", name, act);
  endtask

  task automatic slave_idle();
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rdata   = '0;
    bus.rresp   = 2'b00;
    bus.rlast   = 1'b0;
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    bus.bresp   = 2'b00;
  endtask

  // ---------------- memory slave / bus monitor ----------------
  initial begin : slave
    bit          p_arv, p_ar_hs, p_awv, p_aw_hs, p_wv, p_w_hs, p_r_hs, p_b_hs;
    bit          ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic [35:0] p_ar, p_aw;
    logic [32:0] p_w;
    logic [31:0] a;
    slave_idle();
    p_arv = 0; p_ar_hs = 0; p_awv = 0; p_aw_hs = 0; p_wv = 0; p_w_hs = 0;
    p_r_hs = 0; p_b_hs = 0; p_ar = '0; p_aw = '0; p_w = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        slave_idle();
        rd_q.delete(); wr_q.delete();
        r_beat = 0; w_beat = 0; b_pend = 0;
        p_arv = 0; p_awv = 0; p_wv = 0; p_r_hs = 0; p_b_hs = 0;
        continue;
      end
      if (p_arv && !p_ar_hs) check("ar_hold", {bus.arvalid, bus.araddr, bus.arlen}, {1'b1, p_ar});
      if (p_awv && !p_aw_hs) check("aw_hold", {bus.awvalid, bus.awaddr, bus.awlen}, {1'b1, p_aw});
      if (p_wv && !p_w_hs)   check("w_hold", {bus.wvalid, bus.wlast, bus.wdata}, {1'b1, p_w});

      bus.arready = g_stall ? ($urandom_range(0, 3) == 0) : 1'b1;
      bus.awready = g_stall ? ($urandom_range(0, 3) == 0) : 1'b1;
      bus.wready  = g_stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (!bus.rvalid || p_r_hs) begin
        if (rd_q.size() > 0 && (!g_stall || $urandom_range(0, 2) != 0)) begin
          a = rd_q[0][35:4] + 32'(r_beat * 4);
          bus.rvalid = 1'b1;
          bus.rdata  = mem[widx(a)];
          bus.rlast  = (r_beat == int'(rd_q[0][3:0]));
          bus.rresp  = 2'b00;
        end else begin
          bus.rvalid = 1'b0;
          bus.rlast  = 1'b0;
        end
      end
      if (!bus.bvalid || p_b_hs) begin
        if (b_pend > 0 && (!g_stall || $urandom_range(0, 2) != 0)) begin
          bus.bvalid = 1'b1;
          bus.bresp  = (b_idx == g_err_b) ? 2'b10 : 2'b00;
        end else begin
          bus.bvalid = 1'b0;
          bus.bresp  = 2'b00;
        end
      end

      #1;
      ar_hs = bus.arvalid && bus.arready;
      r_hs  = bus.rvalid && bus.rready;
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      b_hs  = bus.bvalid && bus.bready;

      if (ar_hs) begin
        ar_count++;
        last_arlen = bus.arlen;
        if (exp_ar_q.size() == 0) fail_now("ar_unexpected", {bus.araddr, bus.arlen});
        else check("ar_addr_len", {bus.araddr, bus.arlen}, exp_ar_q.pop_front());
        rd_q.push_back({bus.araddr, bus.arlen});
      end
      if (r_hs) begin
        if (bus.rlast) begin
          void'(rd_q.pop_front());
          r_beat = 0;
        end else r_beat++;
      end
      if (aw_hs) begin
        if (exp_aw_q.size() == 0) fail_now("aw_unexpected", {bus.awaddr, bus.awlen});
        else check("aw_addr_len", {bus.awaddr, bus.awlen}, exp_aw_q.pop_front());
        wr_q.push_back({bus.awaddr, bus.awlen});
      end
      if (w_hs) begin
        if (wr_q.size() == 0) fail_now("w_unexpected", bus.wdata);
        else begin
          a = wr_q[0][35:4] + 32'(w_beat * 4);
          mem[widx(a)] = bus.wdata;
          if (exp_q.size() == 0) fail_now("w_extra", bus.wdata);
          else check("wdata", bus.wdata, exp_q.pop_front());
          check("wlast", bus.wlast, (w_beat == int'(wr_q[0][3:0])));
          if (w_beat == int'(wr_q[0][3:0])) begin
            void'(wr_q.pop_front());
            w_beat = 0;
            b_pend++;
          end else w_beat++;
        end
      end
      if (b_hs) begin
        b_pend--;
        b_idx++;
      end

      p_arv = bus.arvalid; p_ar_hs = ar_hs; p_ar = {bus.araddr, bus.arlen};
      p_awv = bus.awvalid; p_aw_hs = aw_hs; p_aw = {bus.awaddr, bus.awlen};
      p_wv  = bus.wvalid;  p_w_hs  = w_hs;  p_w  = {bus.wlast, bus.wdata};
      p_r_hs = r_hs; p_b_hs = b_hs;
    end
  end

  // ---------------- driver: one copy job ----------------
  task automatic run_copy(input vec_t v);
    int          rem, b, k, cyc, bad;
    logic [31:0] a, d, val;
    logic [31:0] words[$];
    logic [31:0] dsts[$];
    bit          saw_low, poked;
    exp_ar_q.delete(); exp_aw_q.delete(); exp_q.delete();
    g_stall = v.stall; g_err_b = v.err_b; b_idx = 0; ar_count = 0; last_arlen = '0;
    rem = int'(v.len >> 2);
    a = v.src & ~32'h3;
    d = v.dst & ~32'h3;
    k = 0;
    while (rem > 0) begin
      b = (rem > 16) ? 16 : rem;
      exp_ar_q.push_back({a, 4'(b - 1)});
      exp_aw_q.push_back({d, 4'(b - 1)});
      for (int i = 0; i < b; i++) begin
        val = $urandom;
        mem[widx(a + 32'(4 * i))] = val;
        exp_q.push_back(val);
        words.push_back(val);
        dsts.push_back(d + 32'(4 * i));
      end
      a = a + 32'(4 * b);
      d = d + 32'(4 * b);
      rem = rem - b;
`ifdef DMAC_ENGINE_ERR_EN
      if (k == v.err_b) break;
`endif
      k++;
    end

    @(negedge clk);
    src_addr_i = v.src; dst_addr_i = v.dst; byte_len_i = v.len; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("done_after_start", done_o, (v.len[15:2] == 14'd0));
    check("err_cleared", err_o, 1'b0);

    if (v.len[15:2] == 14'd0) begin
      saw_low = 0;
      repeat (20) begin
        @(negedge clk);
        if (!done_o) saw_low = 1;
      end
      check("done_held", saw_low, 1'b0);
    end else begin
      cyc = 0; poked = 0;
      while (!done_o && cyc < 4000) begin
        @(negedge clk);
        cyc++;
        if (start_i) start_i = 1'b0;
        if (v.poke && !poked && dbg_state_o == WDATA) begin
          src_addr_i = 32'h3000; dst_addr_i = 32'h3800; byte_len_i = 16'd8;
          start_i = 1'b1;
          poked = 1;
        end
      end
      start_i = 1'b0;
      if (!done_o) fail_now("done_timeout", cyc);
      if (v.poke) check("poke_in_wdata", poked, 1'b1);
    end

    repeat (3) @(negedge clk);
    check("n_ar", ar_count, v.exp_nar);
    if (v.exp_nar > 0) check("last_arlen", last_arlen, v.exp_last);
    check("ar_left", exp_ar_q.size(), 0);
    check("aw_left", exp_aw_q.size(), 0);
    check("w_left", exp_q.size(), 0);
    check("done_end", done_o, 1'b1);
    check("err_end", err_o, v.exp_err);
    bad = 0;
    foreach (dsts[i]) if (mem[widx(dsts[i])] !== words[i]) bad++;
    check("dst_mem", bad, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    int cyc;
    //          src           dst           len      stall poke err  nar last  err
    vecs[0] = '{32'h0000_1000, 32'h0000_2000, 16'd64,  1'b0, 1'b0, -1, 1, 4'd15, 1'b0};
    vecs[1] = '{32'h0000_1000, 32'h0000_2000, 16'd100, 1'b0, 1'b0, -1, 2, 4'd8,  1'b0};
    vecs[2] = '{32'h0000_1000, 32'h0000_2000, 16'd0,   1'b0, 1'b0, -1, 0, 4'd0,  1'b0};
    vecs[3] = '{32'h0000_1000, 32'h0000_2000, 16'd3,   1'b0, 1'b0, -1, 0, 4'd0,  1'b0};
    vecs[4] = '{32'h0000_1103, 32'h0000_2202, 16'd40,  1'b1, 1'b0, -1, 1, 4'd9,  1'b0};
    vecs[5] = '{32'h0000_1200, 32'h0000_2400, 16'd132, 1'b1, 1'b0, -1, 3, 4'd0,  1'b0};
    vecs[6] = '{32'h0000_1000, 32'h0000_2000, 16'd100, 1'b1, 1'b0, -1, 2, 4'd8,  1'b0};
    vecs[7] = '{32'h0000_1000, 32'h0000_2000, 16'd100, 1'b1, 1'b1, -1, 2, 4'd8,  1'b0};
`ifdef DMAC_ENGINE_ERR_EN
    vecs[8] = '{32'h0000_1000, 32'h0000_2000, 16'd100, 1'b1, 1'b0,  0, 1, 4'd15, 1'b1};
`else
    vecs[8] = '{32'h0000_1000, 32'h0000_2000, 16'd100, 1'b1, 1'b0,  0, 2, 4'd8,  1'b0};
`endif
    vecs[9] = '{32'h0000_1300, 32'h0000_2600, 16'd8,   1'b0, 1'b0, -1, 1, 4'd1,  1'b0};

    repeat (3) @(negedge clk);
    check("rst_done", done_o, 1'b1);
    check("rst_err", err_o, 1'b0);
    check("rst_state", dbg_state_o, IDLE);
    check("rst_valids", {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}, 5'b0);
    check("rst_addr_len", {bus.araddr, bus.arlen, bus.awaddr, bus.awlen}, '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) run_copy(vecs[i]);

    // Reset while the read burst is in flight.
    exp_ar_q.delete(); exp_aw_q.delete(); exp_q.delete();
    exp_ar_q.push_back({32'h0000_1000, 4'hF});
    g_stall = 1'b1; g_err_b = -1;
    @(negedge clk);
    src_addr_i = 32'h1000; dst_addr_i = 32'h2000; byte_len_i = 16'd64; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    cyc = 0;
    while (dbg_state_o != RDATA && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (dbg_state_o != RDATA) fail_now("rdata_timeout", cyc);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_state", dbg_state_o, IDLE);
    check("mid_rst_done", done_o, 1'b1);
    check("mid_rst_valids", {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}, 5'b0);
    check("mid_rst_addr_len", {bus.araddr, bus.arlen, bus.awaddr, bus.awlen}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_ar_q.delete(); exp_aw_q.delete(); exp_q.delete();
    repeat (2) @(negedge clk);
    run_copy(vecs[0]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
